// File: rtl/boot_sequencer_if.sv
// rtl/boot_sequencer_if.sv - EEPROM read port and bootstrap SRAM write bus driven by boot_sequencer
// master = sequencer side, slave = EEPROM/SRAM side.
interface boot_sequencer_if;
  logic [18:0] EEPROM_ADDR;
  logic [7:0]  EEPROM_DATA;
  logic [7:0]  DATA;
  logic [16:0] ADDR;
  logic        MLU_SLICE_N_WE;
  logic        MLU_LOOKAHEAD_N_WE;
  logic        CONTROL_N_WE;
  logic        N_BOOTED;
  logic        BOOT_ERR;

  modport master (
    output EEPROM_ADDR,
    input  EEPROM_DATA,
    output DATA,
    output ADDR,
    output MLU_SLICE_N_WE,
    output MLU_LOOKAHEAD_N_WE,
    output CONTROL_N_WE,
    output N_BOOTED,
    output BOOT_ERR
  );

  modport slave (
    input  EEPROM_ADDR,
    output EEPROM_DATA,
    input  DATA,
    input  ADDR,
    input  MLU_SLICE_N_WE,
    input  MLU_LOOKAHEAD_N_WE,
    input  CONTROL_N_WE,
    input  N_BOOTED,
    input  BOOT_ERR
  );
endinterface

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - power-on EEPROM-to-SRAM loader for MLU slice, MLU lookahead and control tables
// Optional macro BOOT_CHECKSUM_EN: per-region checksum byte verified in CHECK, mismatch latches ERROR.
module boot_sequencer #(
  parameter int SLICE_WORDS     = 131072,
  parameter int LOOKAHEAD_WORDS = 131072,
  parameter int CONTROL_WORDS   = 4096,
  parameter int READ_LATENCY    = 2,
  parameter int STARTUP_CYCLES  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  boot_sequencer_if.master bus
);
  localparam int          STARTUP_N    = (STARTUP_CYCLES < 1) ? 1 : STARTUP_CYCLES;
  localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_N - 1);
  localparam logic [15:0] WAIT_LAST    = 16'(READ_LATENCY - 1);
  localparam logic [1:0]  RG_NONE      = 2'd3;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [15:0] CHECK_LAST   = 16'(READ_LATENCY);
`endif

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_SETUP,
    ST_WAIT,
    ST_STROBE,
    ST_HOLD,
`ifdef BOOT_CHECKSUM_EN
    ST_CHECK,
    ST_ERROR,
`endif
    ST_DONE
  } state_t;

  function automatic logic [31:0] region_size(input logic [1:0] r);
    case (r)
      2'd0:    return 32'(SLICE_WORDS);
      2'd1:    return 32'(LOOKAHEAD_WORDS);
      2'd2:    return 32'(CONTROL_WORDS);
      default: return 32'd0;
    endcase
  endfunction

  // First non-empty region at or after 'from'; empty regions are skipped outright.
  function automatic logic [1:0] region_from(input logic [2:0] from);
    logic [1:0] found;
    found = RG_NONE;
    for (int i = 2; i >= 0; i--) begin
      if (3'(i) >= from && region_size(2'(i)) != 32'd0) found = 2'(i);
    end
    return found;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] startup_q, startup_d;
  logic [15:0] wait_q, wait_d;
  logic [1:0]  region_q, region_d;
  logic [18:0] eaddr_q, eaddr_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  n_we_q, n_we_d;
  logic        n_booted_q, n_booted_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d, check_sum;
  logic        boot_err_q, boot_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    startup_d  = startup_q;
    wait_d     = wait_q;
    region_d   = region_q;
    eaddr_d    = eaddr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    n_we_d     = 3'b111;
    n_booted_d = 1'b1;
`ifdef BOOT_CHECKSUM_EN
    sum_d      = sum_q;
    check_sum  = sum_q + bus.EEPROM_DATA;
    boot_err_d = 1'b0;
`endif

    case (state_q)
      ST_STARTUP: begin
        if (startup_q == STARTUP_LAST) begin
          region_d = region_from(3'd0);
          state_d  = (region_d == RG_NONE) ? ST_DONE : ST_SETUP;
        end else begin
          startup_d = startup_q + 16'd1;
        end
      end
      ST_SETUP: begin
        state_d = ST_WAIT;
        wait_d  = 16'd0;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_STROBE;
        else                     wait_d  = wait_q + 16'd1;
      end
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        // EEPROM address runs on through region ends: the image is contiguous.
        eaddr_d = eaddr_q + 19'd1;
        if ({15'd0, addr_q} == region_size(region_q) - 32'd1) begin
          addr_d = 17'd0;
`ifdef BOOT_CHECKSUM_EN
          state_d = ST_CHECK;
          wait_d  = 16'd0;
`else
          region_d = region_from({1'b0, region_q} + 3'd1);
          state_d  = (region_d == RG_NONE) ? ST_DONE : ST_SETUP;
`endif
        end else begin
          addr_d  = addr_q + 17'd1;
          state_d = ST_SETUP;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHECK: begin
        if (wait_q == CHECK_LAST) begin
          if (check_sum != 8'd0) begin
            state_d = ST_ERROR;
          end else begin
            eaddr_d  = eaddr_q + 19'd1;
            sum_d    = 8'd0;
            region_d = region_from({1'b0, region_q} + 3'd1);
            state_d  = (region_d == RG_NONE) ? ST_DONE : ST_SETUP;
          end
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
`endif
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_STARTUP;
    endcase

    // Capture entering the last WAIT cycle so DATA leads the strobe by a full cycle.
    if (state_d == ST_WAIT && wait_d == WAIT_LAST) begin
      data_d = bus.EEPROM_DATA;
`ifdef BOOT_CHECKSUM_EN
      sum_d  = sum_q + bus.EEPROM_DATA;
`endif
    end

    if (state_d == ST_STROBE) begin
      case (region_d)
        2'd0:    n_we_d = 3'b110;
        2'd1:    n_we_d = 3'b101;
        2'd2:    n_we_d = 3'b011;
        default: n_we_d = 3'b111;
      endcase
    end
    n_booted_d = (state_d != ST_DONE);
`ifdef BOOT_CHECKSUM_EN
    boot_err_d = (state_d == ST_ERROR);
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_STARTUP;
      startup_q  <= 16'd0;
      wait_q     <= 16'd0;
      region_q   <= 2'd0;
      eaddr_q    <= 19'd0;
      addr_q     <= 17'd0;
      data_q     <= 8'd0;
      n_we_q     <= 3'b111;
      n_booted_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      startup_q  <= startup_d;
      wait_q     <= wait_d;
      region_q   <= region_d;
      eaddr_q    <= eaddr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      n_we_q     <= n_we_d;
      n_booted_q <= n_booted_d;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum_q      <= 8'd0;
      boot_err_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      boot_err_q <= boot_err_d;
    end
  end
  assign bus.BOOT_ERR = boot_err_q;
`else
  assign bus.BOOT_ERR = 1'b0;
`endif

  assign bus.EEPROM_ADDR        = eaddr_q;
  assign bus.ADDR               = addr_q;
  assign bus.DATA               = data_q;
  assign bus.MLU_SLICE_N_WE     = n_we_q[0];
  assign bus.MLU_LOOKAHEAD_N_WE = n_we_q[1];
  assign bus.CONTROL_N_WE       = n_we_q[2];
  assign bus.N_BOOTED           = n_booted_q;
endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - self-checking bench for boot_sequencer against a per-byte load model
// Builds with or without BOOT_CHECKSUM_EN; the model follows the macro.
module tb_boot_sequencer;
  localparam int SW = 4, LW = 2, CW = 3, RL = 2, SC = 3;
`ifdef BOOT_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  localparam int MAXC = 128;

  typedef struct packed {
    int tgt;
    int addr;
    int data;
    int eaddr;
    int cyc;
  } wr_t;

  logic CLK = 1'b0;
  logic rst_a, rst_z;
  always #5 CLK = ~CLK;

  boot_sequencer_if bus_a ();
  boot_sequencer_if bus_z ();

  logic [7:0]  mem_a [32];
  logic [7:0]  mem_z [32];
  logic [18:0] ra_a, ra_z;

  // One register stage on the address gives data valid two cycles after an address change.
  always @(posedge CLK) begin
    ra_a <= bus_a.EEPROM_ADDR;
    ra_z <= bus_z.EEPROM_ADDR;
  end
  assign bus_a.EEPROM_DATA = mem_a[ra_a[4:0]];
  assign bus_z.EEPROM_DATA = mem_z[ra_z[4:0]];

  boot_sequencer #(.SLICE_WORDS(SW), .LOOKAHEAD_WORDS(LW), .CONTROL_WORDS(CW),
                   .READ_LATENCY(RL), .STARTUP_CYCLES(SC))
    dut (.CLK(CLK), .RST(rst_a), .bus(bus_a));

  boot_sequencer #(.SLICE_WORDS(SW), .LOOKAHEAD_WORDS(0), .CONTROL_WORDS(CW),
                   .READ_LATENCY(RL), .STARTUP_CYCLES(SC))
    dut_z (.CLK(CLK), .RST(rst_z), .bus(bus_z));

  int n_pass, n_total;
  wr_t exp_q[$];
  wr_t got_q[$];
  int exp_done, exp_err;

  logic [2:0]  c_nwe   [MAXC];
  logic [16:0] c_addr  [MAXC];
  logic [7:0]  c_data  [MAXC];
  logic [18:0] c_eaddr [MAXC];
  logic        c_nb    [MAXC];
  logic        c_err   [MAXC];

  task automatic fill_mem(input int sel, input bit rnd, input int lw);
    logic [7:0] m [32];
    int sizes[3];
    int base;
    logic [7:0] s;
    for (int a = 0; a < 32; a++) m[a] = rnd ? 8'($urandom) : (8'(a) ^ 8'hA5);
    sizes = '{SW, lw, CW};
    base = 0;
    if (CSUM != 0) begin
      for (int r = 0; r < 3; r++) begin
        if (sizes[r] != 0) begin
          s = 8'd0;
          for (int i = 0; i < sizes[r]; i++) s = s + m[base + i];
          m[base + sizes[r]] = 8'h00 - s;
          base = base + sizes[r] + 1;
        end
      end
    end
    if (sel == 0) mem_a = m;
    else          mem_z = m;
  endtask

  // Reference: walk regions in order, one write per byte every RL+3 cycles, checksum adds 1+RL.
  function automatic void build_model(input int sel, input int lw);
    int sizes[3];
    int base, t_bytes, n_chk, sum, d;
    sizes = '{SW, lw, CW};
    base = 0; t_bytes = 0; n_chk = 0;
    exp_q.delete();
    exp_done = -1;
    exp_err = -1;
    for (int r = 0; r < 3; r++) begin
      if (sizes[r] != 0) begin
        sum = 0;
        for (int i = 0; i < sizes[r]; i++) begin
          d = (sel == 0) ? int'(mem_a[base + i]) : int'(mem_z[base + i]);
          sum += d;
          exp_q.push_back('{r, i, d, base + i, SC + 1 + RL + t_bytes * (RL + 3) + n_chk * (1 + RL)});
          t_bytes++;
        end
        base += sizes[r];
        if (CSUM != 0) begin
          sum += (sel == 0) ? int'(mem_a[base]) : int'(mem_z[base]);
          base++;
          n_chk++;
          if (sum % 256 != 0) begin
            exp_err = SC + t_bytes * (RL + 3) + n_chk * (1 + RL);
            return;
          end
        end
      end
    end
    exp_done = SC + t_bytes * (RL + 3) + n_chk * (1 + RL);
  endfunction

  task automatic sample(input int sel, input int c);
    if (sel == 0) begin
      c_nwe[c]   = {bus_a.CONTROL_N_WE, bus_a.MLU_LOOKAHEAD_N_WE, bus_a.MLU_SLICE_N_WE};
      c_addr[c]  = bus_a.ADDR;
      c_data[c]  = bus_a.DATA;
      c_eaddr[c] = bus_a.EEPROM_ADDR;
      c_nb[c]    = bus_a.N_BOOTED;
      c_err[c]   = bus_a.BOOT_ERR;
    end else begin
      c_nwe[c]   = {bus_z.CONTROL_N_WE, bus_z.MLU_LOOKAHEAD_N_WE, bus_z.MLU_SLICE_N_WE};
      c_addr[c]  = bus_z.ADDR;
      c_data[c]  = bus_z.DATA;
      c_eaddr[c] = bus_z.EEPROM_ADDR;
      c_nb[c]    = bus_z.N_BOOTED;
      c_err[c]   = bus_z.BOOT_ERR;
    end
  endtask

  task automatic capture(input int sel, input int n);
    sample(sel, 0);
    for (int c = 1; c <= n; c++) begin
      @(posedge CLK);
      #1;
      sample(sel, c);
    end
  endtask

  task automatic check_load(input string tag, input int n);
    wr_t w;
    int zeros, tgt, onehot_bad, stab_bad, nb_fall, err_rise;
    bit nb_bounce, err_bounce;
    got_q.delete();
    onehot_bad = 0; stab_bad = 0; nb_fall = -1; err_rise = -1;
    nb_bounce = 0; err_bounce = 0;
    for (int c = 1; c <= n; c++) begin
      zeros = 0; tgt = -1;
      for (int b = 0; b < 3; b++) if (c_nwe[c][b] !== 1'b1) begin zeros++; tgt = b; end
      if (zeros > 1) onehot_bad++;
      if (zeros == 1) begin
        if (c_addr[c-1] !== c_addr[c] || c_addr[c+1] !== c_addr[c] ||
            c_data[c-1] !== c_data[c] || c_data[c+1] !== c_data[c]) stab_bad++;
        w = '{tgt, int'(c_addr[c]), int'(c_data[c]), int'(c_eaddr[c]), c};
        got_q.push_back(w);
      end
      if (c_nb[c] === 1'b0 && nb_fall < 0) nb_fall = c;
      else if (c_nb[c] !== 1'b0 && nb_fall >= 0) nb_bounce = 1;
      if (c_err[c] === 1'b1 && err_rise < 0) err_rise = c;
      else if (c_err[c] !== 1'b1 && err_rise >= 0) err_bounce = 1;
    end
    if (nb_bounce) nb_fall = -2;
    if (err_bounce) err_rise = -2;

    n_total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL %s strobe_count got %0d expected %0d", tag, got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_total++;
      if (i >= got_q.size())
        $display("FAIL %s write%0d missing, expected tgt=%0d addr=%0d data=%02h", tag, i,
                 exp_q[i].tgt, exp_q[i].addr, exp_q[i].data);
      else if (got_q[i] !== exp_q[i])
        $display("FAIL %s write%0d got tgt=%0d addr=%0d data=%02h eaddr=%0d cyc=%0d expected tgt=%0d addr=%0d data=%02h eaddr=%0d cyc=%0d",
                 tag, i, got_q[i].tgt, got_q[i].addr, got_q[i].data, got_q[i].eaddr, got_q[i].cyc,
                 exp_q[i].tgt, exp_q[i].addr, exp_q[i].data, exp_q[i].eaddr, exp_q[i].cyc);
      else n_pass++;
    end
    n_total++;
    if (onehot_bad != 0) $display("FAIL %s strobe_onehot got %0d bad cycles expected 0", tag, onehot_bad);
    else n_pass++;
    n_total++;
    if (stab_bad != 0) $display("FAIL %s addr_data_stable got %0d unstable strobes expected 0", tag, stab_bad);
    else n_pass++;
    n_total++;
    if (nb_fall != exp_done) $display("FAIL %s n_booted_fall got cycle %0d expected %0d", tag, nb_fall, exp_done);
    else n_pass++;
    n_total++;
    if (err_rise != exp_err) $display("FAIL %s boot_err_rise got cycle %0d expected %0d", tag, err_rise, exp_err);
    else n_pass++;
  endtask

  task automatic run_load(input int sel, input string tag);
    int n;
    n = ((exp_done > 0) ? exp_done : exp_err) + 6;
    if (sel == 0) rst_a = 1'b1; else rst_z = 1'b1;
    repeat (2) @(negedge CLK);
    if (sel == 0) rst_a = 1'b0; else rst_z = 1'b0;
    capture(sel, n + 1);
    check_load(tag, n);
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_z = 1'b1;
    repeat (3) @(negedge CLK);
    n_total++;
    if ({bus_a.EEPROM_ADDR, bus_a.DATA, bus_a.ADDR, bus_a.CONTROL_N_WE, bus_a.MLU_LOOKAHEAD_N_WE,
         bus_a.MLU_SLICE_N_WE, bus_a.N_BOOTED, bus_a.BOOT_ERR} !== {19'd0, 8'd0, 17'd0, 3'b111, 1'b1, 1'b0})
      $display("FAIL reset_a got eaddr=%0d data=%02h addr=%0d nwe=%b%b%b nb=%b err=%b expected 0/00/0/111/1/0",
               bus_a.EEPROM_ADDR, bus_a.DATA, bus_a.ADDR, bus_a.CONTROL_N_WE, bus_a.MLU_LOOKAHEAD_N_WE,
               bus_a.MLU_SLICE_N_WE, bus_a.N_BOOTED, bus_a.BOOT_ERR);
    else n_pass++;
    n_total++;
    if ({bus_z.EEPROM_ADDR, bus_z.DATA, bus_z.ADDR, bus_z.CONTROL_N_WE, bus_z.MLU_LOOKAHEAD_N_WE,
         bus_z.MLU_SLICE_N_WE, bus_z.N_BOOTED, bus_z.BOOT_ERR} !== {19'd0, 8'd0, 17'd0, 3'b111, 1'b1, 1'b0})
      $display("FAIL reset_z got eaddr=%0d data=%02h addr=%0d nb=%b err=%b expected 0/00/0/1/0",
               bus_z.EEPROM_ADDR, bus_z.DATA, bus_z.ADDR, bus_z.N_BOOTED, bus_z.BOOT_ERR);
    else n_pass++;
  endtask

  task automatic test_full_load();
    fill_mem(0, 1'b0, LW);
    build_model(0, LW);
    run_load(0, "full_load");
  endtask

  task automatic test_random_load();
    for (int k = 0; k < 3; k++) begin
      fill_mem(0, 1'b1, LW);
      build_model(0, LW);
      run_load(0, "random_load");
    end
  endtask

  task automatic test_reset_mid_load();
    int target, n;
    fill_mem(0, 1'b1, LW);
    build_model(0, LW);
    target = exp_q[SW + 1].cyc;
    n = exp_done + 6;
    rst_a = 1'b1;
    repeat (2) @(negedge CLK);
    rst_a = 1'b0;
    for (int c = 1; c <= target; c++) begin
      @(posedge CLK);
      #1;
    end
    n_total++;
    if (bus_a.MLU_LOOKAHEAD_N_WE !== 1'b0)
      $display("FAIL midload_strobe got lookahead_n_we=%b expected 0 at cycle %0d", bus_a.MLU_LOOKAHEAD_N_WE, target);
    else n_pass++;
    #2 rst_a = 1'b1;
    #1;
    n_total++;
    if ({bus_a.EEPROM_ADDR, bus_a.DATA, bus_a.ADDR, bus_a.CONTROL_N_WE, bus_a.MLU_LOOKAHEAD_N_WE,
         bus_a.MLU_SLICE_N_WE, bus_a.N_BOOTED} !== {19'd0, 8'd0, 17'd0, 3'b111, 1'b1})
      $display("FAIL midload_async_reset got eaddr=%0d data=%02h addr=%0d nwe=%b%b%b nb=%b expected 0/00/0/111/1",
               bus_a.EEPROM_ADDR, bus_a.DATA, bus_a.ADDR, bus_a.CONTROL_N_WE, bus_a.MLU_LOOKAHEAD_N_WE,
               bus_a.MLU_SLICE_N_WE, bus_a.N_BOOTED);
    else n_pass++;
    repeat (2) @(negedge CLK);
    rst_a = 1'b0;
    capture(0, n + 1);
    check_load("restart", n);
  endtask

  task automatic test_zero_region();
    fill_mem(1, 1'b1, 0);
    build_model(1, 0);
    run_load(1, "zero_region");
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum_fail();
    fill_mem(0, 1'b0, LW);
    mem_a[5] = mem_a[5] ^ 8'h01;
    build_model(0, LW);
    run_load(0, "checksum_fail");
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_full_load();
    test_random_load();
    test_reset_mid_load();
    test_zero_region();
`ifdef BOOT_CHECKSUM_EN
    test_checksum_fail();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
